// File: rtl/alu_unit.sv
// Execution stage at the end of the RS->ALU dispatch path. It is fully pipelined with no backpressure,
// and the result is always registered. Defining ALU_PIPE2_EN adds an operand-latch stage, which makes the latency 2 cycles.
module alu_unit #(
  parameter int XLEN = 32,
  parameter int ID_W = 4,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            rs_ready,
  input  logic [OP_W-1:0] rs_op,
  input  logic [XLEN-1:0] rs_val1,
  input  logic [XLEN-1:0] rs_val2,
  input  logic [ID_W-1:0] rs_id,
  output logic            alu_ready,
  output logic [XLEN-1:0] alu_res,
  output logic [ID_W-1:0] alu_id,
  output logic            alu_bad_op
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SHRA = OP_W'(7);
  localparam logic [OP_W-1:0] OP_EQ   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_NEQ  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_LT   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_LTU  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_GE   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_GEU  = OP_W'(13);

  logic            c_valid;
  logic [OP_W-1:0] c_op;
  logic [XLEN-1:0] c_a;
  logic [XLEN-1:0] c_b;
  logic [ID_W-1:0] c_id;
  logic [XLEN-1:0] res_next;
  logic            bad_next;
  logic [4:0]      sh;

`ifdef ALU_PIPE2_EN
  logic            s1_valid_reg;
  logic [OP_W-1:0] s1_op_reg;
  logic [XLEN-1:0] s1_a_reg;
  logic [XLEN-1:0] s1_b_reg;
  logic [ID_W-1:0] s1_id_reg;

  // Operand latch; an op issued during a flush never becomes valid.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        s1_valid_reg <= 1'b0;
        s1_op_reg    <= '0;
        s1_a_reg     <= '0;
        s1_b_reg     <= '0;
        s1_id_reg    <= '0;
      end else begin
        s1_valid_reg <= rs_ready & ~flush;
        s1_op_reg    <= rs_op;
        s1_a_reg     <= rs_val1;
        s1_b_reg     <= rs_val2;
        s1_id_reg    <= rs_id;
      end
    end
  end

  assign c_valid = s1_valid_reg;
  assign c_op    = s1_op_reg;
  assign c_a     = s1_a_reg;
  assign c_b     = s1_b_reg;
  assign c_id    = s1_id_reg;
`else
  assign c_valid = rs_ready;
  assign c_op    = rs_op;
  assign c_a     = rs_val1;
  assign c_b     = rs_val2;
  assign c_id    = rs_id;
`endif

  assign sh = c_b[4:0];

  always_comb begin
    res_next = '0;
    bad_next = 1'b0;
    case (c_op)
      OP_ADD:  res_next = c_a + c_b;
      OP_SUB:  res_next = c_a - c_b;
      OP_AND:  res_next = c_a & c_b;
      OP_OR:   res_next = c_a | c_b;
      OP_XOR:  res_next = c_a ^ c_b;
      OP_SHL:  res_next = c_a << sh;
      OP_SHR:  res_next = c_a >> sh;
      OP_SHRA: res_next = $unsigned($signed(c_a) >>> sh);
      OP_EQ:   res_next = XLEN'(c_a == c_b);
      OP_NEQ:  res_next = XLEN'(c_a != c_b);
      OP_LT:   res_next = XLEN'($signed(c_a) < $signed(c_b));
      OP_LTU:  res_next = XLEN'(c_a < c_b);
      OP_GE:   res_next = XLEN'($signed(c_a) >= $signed(c_b));
      OP_GEU:  res_next = XLEN'(c_a >= c_b);
      default: bad_next = 1'b1;
    endcase
  end

  // Undefined opcodes still retire (result 0) so the ROB entry completes.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        alu_ready  <= 1'b0;
        alu_res    <= '0;
        alu_id     <= '0;
        alu_bad_op <= 1'b0;
      end else if (flush) begin
        alu_ready <= 1'b0;
      end else begin
        alu_ready <= c_valid;
        if (c_valid) begin
          alu_res <= res_next;
          alu_id  <= c_id;
          if (bad_next) alu_bad_op <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Testbench for alu_unit. It uses directed vectors, an op-queue reference model checked on every
// cycle, and literal checks on the logged result pulses.
module tb_alu_unit;

`ifdef ALU_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4, A_SHL = 5, A_SHR = 6,
                 A_SHRA = 7, A_EQ = 8, A_NEQ = 9, A_LT = 10, A_LTU = 11, A_GE = 12, A_GEU = 13,
                 A_BAD = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        rs_ready = 1'b0;
  logic [3:0]  rs_op = '0;
  logic [31:0] rs_val1 = '0;
  logic [31:0] rs_val2 = '0;
  logic [3:0]  rs_id = '0;
  logic        alu_ready;
  logic [31:0] alu_res;
  logic [3:0]  alu_id;
  logic        alu_bad_op;

  alu_unit #(.XLEN(32), .ID_W(4), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .rs_ready(rs_ready), .rs_op(rs_op), .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_id(rs_id),
    .alu_ready(alu_ready), .alu_res(alu_res), .alu_id(alu_id), .alu_bad_op(alu_bad_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference semantics of each opcode, in plain arithmetic.
  function automatic void model_op(input int op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output bit bad);
    int sa, sb;
    int unsigned sh;
    sa = a; sb = b; sh = b & 32'd31;
    bad = 0;
    case (op)
      A_ADD:  r = a + b;
      A_SUB:  r = a - b;
      A_AND:  r = a & b;
      A_OR:   r = a | b;
      A_XOR:  r = a ^ b;
      A_SHL:  r = a << sh;
      A_SHR:  r = a >> sh;
      A_SHRA: r = sa >>> sh;
      A_EQ:   r = (a == b) ? 1 : 0;
      A_NEQ:  r = (a != b) ? 1 : 0;
      A_LT:   r = (sa < sb) ? 1 : 0;
      A_LTU:  r = (a < b) ? 1 : 0;
      A_GE:   r = (sa >= sb) ? 1 : 0;
      A_GEU:  r = (a >= b) ? 1 : 0;
      default: begin r = 0; bad = 1; end
    endcase
  endfunction

  typedef struct { logic [31:0] res; logic [3:0] id; bit bad; int age; } ent_t;
  ent_t pend[$];
  bit          exp_ready = 0;
  logic [31:0] exp_res = '0;
  logic [3:0]  exp_id = '0;
  bit          exp_bad = 0;
  bit          exp_zero = 0;

  // Each accepted op ages by one per enabled edge and leaves after LAT edges. A flush drops all pending ops.
  always @(posedge clk) begin
    ent_t e;
    cyc++;
    if (rdy) begin
      if (rst) begin
        pend.delete();
        exp_ready = 0; exp_res = '0; exp_id = '0; exp_bad = 0; exp_zero = 1;
      end else if (flush) begin
        pend.delete();
        exp_ready = 0;
      end else begin
        if (rs_ready) begin
          model_op(int'(rs_op), rs_val1, rs_val2, e.res, e.bad);
          e.id = rs_id; e.age = 0;
          pend.push_back(e);
        end
        foreach (pend[i]) pend[i].age++;
        exp_ready = 0;
        if (pend.size() > 0 && pend[0].age >= LAT) begin
          e = pend.pop_front();
          exp_ready = 1; exp_res = e.res; exp_id = e.id; exp_zero = 0;
          if (e.bad) exp_bad = 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("alu_ready", 32'(alu_ready), 32'(exp_ready));
      chk("alu_bad_op", 32'(alu_bad_op), 32'(exp_bad));
      if (exp_ready || exp_zero) begin
        chk("alu_res", alu_res, exp_res);
        chk("alu_id", 32'(alu_id), 32'(exp_id));
      end
    end
  end

  typedef struct { logic [31:0] res; logic [3:0] id; int c; } pulse_t;
  pulse_t plog[$];

  always @(negedge clk) begin
    pulse_t p;
    if (started && alu_ready) begin
      p.res = alu_res; p.id = alu_id; p.c = cyc;
      plog.push_back(p);
      $display("pulse cycle %0d: res=%h id=%0d", cyc, alu_res, alu_id);
    end
  end

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] id);
    rs_ready = 1; rs_op = op[3:0]; rs_val1 = a; rs_val2 = b; rs_id = id;
    @(negedge clk);
    rs_ready = 0;
  endtask

  task automatic drain();
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic chk_pulse(input string name, input int idx, input logic [31:0] res, input logic [3:0] id);
    if (idx >= plog.size()) begin
      checks++; errors++;
      $display("FAIL %s: pulse %0d missing, got %0d pulses", name, idx, plog.size());
    end else begin
      chk({name, "_res"}, plog[idx].res, res);
      chk({name, "_id"}, 32'(plog[idx].id), 32'(id));
    end
  endtask

  initial begin
    @(negedge clk);
    started = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_ready", 32'(alu_ready), 0);
    chk("reset_res", alu_res, 0);
    chk("reset_id", 32'(alu_id), 0);
    chk("reset_bad", 32'(alu_bad_op), 0);

    plog.delete();
    issue(A_ADD, 7, 5, 3);
    issue(A_SUB, 0, 1, 4);
    drain();
    chk("t2_count", plog.size(), 2);
    chk_pulse("t2_add", 0, 32'd12, 3);
    chk_pulse("t2_sub", 1, 32'hFFFF_FFFF, 4);
    if (plog.size() == 2) chk("t2_b2b", plog[1].c - plog[0].c, 1);

    plog.delete();
    issue(A_SHRA, 32'h8000_0000, 32'h24, 1);
    issue(A_SHR, 32'h8000_0000, 32'h24, 2);
    issue(A_SHL, 1, 31, 3);
    issue(A_XOR, 32'hF0F0_0000, 32'h0FF0_1234, 4);
    drain();
    chk_pulse("t3_shra", 0, 32'hF800_0000, 1);
    chk_pulse("t3_shr", 1, 32'h0800_0000, 2);
    chk_pulse("t3_shl", 2, 32'h8000_0000, 3);
    chk_pulse("t3_xor", 3, 32'hFF00_1234, 4);

    plog.delete();
    issue(A_LT, 32'hFFFF_FFFF, 1, 5);
    issue(A_LTU, 32'hFFFF_FFFF, 1, 6);
    issue(A_GEU, 5, 5, 7);
    issue(A_NEQ, 5, 5, 8);
    issue(A_GE, 32'hFFFF_FFFF, 1, 9);
    issue(A_EQ, 9, 9, 10);
    drain();
    chk_pulse("t4_lt", 0, 1, 5);
    chk_pulse("t4_ltu", 1, 0, 6);
    chk_pulse("t4_geu", 2, 1, 7);
    chk_pulse("t4_neq", 3, 0, 8);
    chk_pulse("t4_ge", 4, 0, 9);
    chk_pulse("t4_eq", 5, 1, 10);

    plog.delete();
`ifdef ALU_PIPE2_EN
    issue(A_ADD, 100, 1, 5);
`endif
    flush = 1;
    issue(A_ADD, 200, 1, 6);
    flush = 0;
    @(negedge clk);
    issue(A_ADD, 1, 1, 7);
    drain();
    chk("t5_count", plog.size(), 1);
    chk_pulse("t5_after", 0, 2, 7);

    plog.delete();
    rdy = 0;
    rs_ready = 1; rs_op = 4'(A_ADD); rs_val1 = 2; rs_val2 = 3; rs_id = 9;
    repeat (3) begin
      @(negedge clk);
      chk("t6_hold_ready", 32'(alu_ready), 0);
      rs_val1 = rs_val1 + 10;
    end
    rs_val1 = 2;
    rdy = 1;
    @(negedge clk);
    rs_ready = 0;
    drain();
    chk("t6_count", plog.size(), 1);
    chk_pulse("t6_add", 0, 5, 9);

    plog.delete();
    issue(A_BAD, 1, 2, 11);
    drain();
    chk_pulse("t6_bad", 0, 0, 11);
    chk("t6_bad_flag", 32'(alu_bad_op), 1);
    issue(A_OR, 32'h0F, 32'hF0, 12);
    drain();
    chk_pulse("t6_or", 1, 32'hFF, 12);
    chk("t6_bad_sticky", 32'(alu_bad_op), 1);

    plog.delete();
    rst = 1; flush = 1;
    issue(A_BAD, 3, 3, 13);
    rst = 0; flush = 0;
    drain();
    chk("t7_no_pulse", plog.size(), 0);
    chk("t7_bad_clear", 32'(alu_bad_op), 0);
    chk("t7_res", alu_res, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
